// File: rtl/data_mem_resp.sv
// Byte-addressable 32-bit data memory with a req/ack handshake and a programmable wait time.
// Loads are formatted from a registered block-RAM read; stores commit with per-lane byte enables.
module data_mem_resp #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic        write,
    input  logic [31:0] wdata,
    input  logic        extend,
    input  logic [1:0]  width,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);
    localparam int         AW     = $clog2(DEPTH);
    localparam logic [3:0] LAT    = 4'(LATENCY);
    localparam logic [1:0] W_BYTE = 2'd0;
    localparam logic [1:0] W_HALF = 2'd1;
    localparam logic [1:0] W_WORD = 2'd2;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  count_reg, count_next;
    logic        capture;

    logic [AW+1:0] addr_reg;
    logic          write_reg;
    logic [31:0]   wdata_reg;
    logic          extend_reg;
    logic [1:0]    width_reg;

    logic [AW-1:0] word_idx;
    logic [AW-1:0] read_idx;
    logic          misaligned;
    logic          commit;
    logic [3:0]    byte_en;
    logic [31:0]   store_word;
    logic [31:0]   mem_q_reg;
    logic [7:0]    lane [4];
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_val;
    logic [31:0]   rdata_reg;
    logic          unused_addr_bits;

    logic [31:0] mem [0:DEPTH-1];

    // Address bits above the memory size are ignored, so the space wraps.
    assign unused_addr_bits = ^addr[31:AW+2];

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    if (LAT == 4'd0) begin
                        state_next = ACK;
                    end else begin
                        state_next = WAIT;
                        count_next = LAT;
                    end
                end
            end
            WAIT: begin
                if (count_reg <= 4'd1) begin
                    state_next = ACK;
                    count_next = 4'd0;
                end else begin
                    count_next = count_reg - 4'd1;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                count_next = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            count_reg <= 4'd0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            addr_reg   <= addr[AW+1:0];
            write_reg  <= write;
            wdata_reg  <= wdata;
            extend_reg <= extend;
            width_reg  <= width;
        end
    end

    assign ack = (state_reg == ACK);
    assign err = ack && misaligned;

    always_comb begin
        misaligned = 1'b0;
        case (width_reg)
            W_BYTE:  misaligned = 1'b0;
            W_HALF:  misaligned = addr_reg[0];
            W_WORD:  misaligned = (addr_reg[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        byte_en    = 4'b0000;
        store_word = wdata_reg;
        case (width_reg)
            W_BYTE: begin
                byte_en    = 4'b0001 << addr_reg[1:0];
                store_word = {4{wdata_reg[7:0]}};
            end
            W_HALF: begin
                byte_en    = addr_reg[1] ? 4'b1100 : 4'b0011;
                store_word = {2{wdata_reg[15:0]}};
            end
            W_WORD: begin
                byte_en    = 4'b1111;
                store_word = wdata_reg;
            end
            default: begin
                byte_en    = 4'b0000;
                store_word = wdata_reg;
            end
        endcase
    end

    // Gating with reset_n lets a reset during ACK abort the pending store.
    assign commit   = ack && write_reg && !misaligned && reset_n;
    assign word_idx = addr_reg[AW+1:2];
    // While idle, read ahead at the incoming address so a zero-latency access has its data in ACK.
    assign read_idx = (state_reg == IDLE) ? addr[AW+1:2] : word_idx;

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][i*8 +: 8] <= store_word[i*8 +: 8];
                end
            end
        end
        mem_q_reg <= mem[read_idx];
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = mem_q_reg[gi*8 +: 8];
        end
    endgenerate

    assign byte_sel = lane[addr_reg[1:0]];
    assign half_sel = addr_reg[1] ? mem_q_reg[31:16] : mem_q_reg[15:0];

    always_comb begin
        load_val = mem_q_reg;
        case (width_reg)
            W_BYTE:  load_val = {{24{extend_reg & byte_sel[7]}}, byte_sel};
            W_HALF:  load_val = {{16{extend_reg & half_sel[15]}}, half_sel};
            default: load_val = mem_q_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata_reg <= 32'd0;
        end else if (ack && !write_reg) begin
            rdata_reg <= misaligned ? 32'd0 : load_val;
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: three instances at LATENCY 1, 0 and 3 sharing one clock.
module tb_data_mem_resp;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       reset_n_v;
    logic [2:0]       req_v;
    logic [2:0][31:0] addr_v;
    logic [2:0]       write_v;
    logic [2:0][31:0] wdata_v;
    logic [2:0]       extend_v;
    logic [2:0][1:0]  width_v;
    logic [2:0]       ack_v;
    logic [2:0][31:0] rdata_v;
    logic [2:0]       err_v;

    int tests = 0;
    int fails = 0;
    int lat_tab [3] = '{1, 0, 3};

    data_mem_resp #(.DEPTH(1024), .LATENCY(1)) u_lat1 (
        .clk(clk), .reset_n(reset_n_v[0]), .req(req_v[0]), .addr(addr_v[0]),
        .write(write_v[0]), .wdata(wdata_v[0]), .extend(extend_v[0]), .width(width_v[0]),
        .ack(ack_v[0]), .rdata(rdata_v[0]), .err(err_v[0])
    );
    data_mem_resp #(.DEPTH(1024), .LATENCY(0)) u_lat0 (
        .clk(clk), .reset_n(reset_n_v[1]), .req(req_v[1]), .addr(addr_v[1]),
        .write(write_v[1]), .wdata(wdata_v[1]), .extend(extend_v[1]), .width(width_v[1]),
        .ack(ack_v[1]), .rdata(rdata_v[1]), .err(err_v[1])
    );
    data_mem_resp #(.DEPTH(1024), .LATENCY(3)) u_lat3 (
        .clk(clk), .reset_n(reset_n_v[2]), .req(req_v[2]), .addr(addr_v[2]),
        .write(write_v[2]), .wdata(wdata_v[2]), .extend(extend_v[2]), .width(width_v[2]),
        .ack(ack_v[2]), .rdata(rdata_v[2]), .err(err_v[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one access in the current cycle, wait for ack, and land in the following idle cycle.
    task automatic access(input int u, input logic wr, input logic [1:0] w, input logic [31:0] a,
                          input logic [31:0] wd, input logic ext, input logic drop,
                          input logic exp_err, input string tag);
        int n;
        req_v[u]    = 1'b1;
        write_v[u]  = wr;
        width_v[u]  = w;
        addr_v[u]   = a;
        wdata_v[u]  = wd;
        extend_v[u] = ext;
        n = 0;
        do begin
            tick();
            n++;
            if (drop) req_v[u] = 1'b0;
        end while (!ack_v[u] && n < 20);
        check({tag, " ack latency"}, 32'(n), 32'(lat_tab[u] + 1));
        check({tag, " err"}, 32'(err_v[u]), 32'(exp_err));
        req_v[u] = 1'b0;
        tick();
        check({tag, " ack single cycle"}, 32'(ack_v[u]), 32'd0);
        $display("[TB] u%0d %s done after %0d cycles, rdata=0x%08h", u, tag, n, rdata_v[u]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n_v = '0;
        req_v     = '0;
        addr_v    = '0;
        write_v   = '0;
        wdata_v   = '0;
        extend_v  = '0;
        width_v   = '0;
        repeat (3) tick();
        for (int u = 0; u < 3; u++) begin
            check($sformatf("u%0d reset ack", u), 32'(ack_v[u]), 32'd0);
            check($sformatf("u%0d reset err", u), 32'(err_v[u]), 32'd0);
            check($sformatf("u%0d reset rdata", u), rdata_v[u], 32'd0);
        end
        reset_n_v = '1;

        // LATENCY=1: word store/load, then rdata untouched by stores
        access(0, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, "st_w 0x10");
        check("rdata after store", rdata_v[0], 32'd0);
        access(0, 1'b0, 2'd2, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, "ld_w 0x10");
        check("ld_w 0x10 rdata", rdata_v[0], 32'hDEADBEEF);

        // Byte store into lane 3 and sign/zero-extended loads
        access(0, 1'b1, 2'd2, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, "clr 0x10");
        access(0, 1'b1, 2'd0, 32'h13, 32'hABCDEF80, 1'b0, 1'b0, 1'b0, "st_b 0x13");
        access(0, 1'b0, 2'd0, 32'h13, 32'h0, 1'b1, 1'b0, 1'b0, "ld_b sx 0x13");
        check("ld_b sx 0x13 rdata", rdata_v[0], 32'hFFFFFF80);
        access(0, 1'b0, 2'd0, 32'h13, 32'h0, 1'b0, 1'b0, 1'b0, "ld_b zx 0x13");
        check("ld_b zx 0x13 rdata", rdata_v[0], 32'h00000080);
        access(0, 1'b0, 2'd2, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, "ld_w after st_b");
        check("ld_w after st_b rdata", rdata_v[0], 32'h80000000);

        // Misaligned half load clears rdata
        access(0, 1'b0, 2'd1, 32'h11, 32'h0, 1'b0, 1'b0, 1'b1, "ld_h 0x11 misaligned");
        check("ld_h 0x11 rdata", rdata_v[0], 32'd0);

        // Upper half store and half load
        access(0, 1'b1, 2'd1, 32'h12, 32'h1234BEEF, 1'b0, 1'b0, 1'b0, "st_h 0x12");
        access(0, 1'b0, 2'd2, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, "ld_w after st_h");
        check("ld_w after st_h rdata", rdata_v[0], 32'hBEEF0000);
        access(0, 1'b0, 2'd1, 32'h12, 32'h0, 1'b1, 1'b0, 1'b0, "ld_h sx 0x12");
        check("ld_h sx 0x12 rdata", rdata_v[0], 32'hFFFFBEEF);

        // Reserved width store must not write
        access(0, 1'b1, 2'd2, 32'h20, 32'h11223344, 1'b0, 1'b0, 1'b0, "st_w 0x20");
        access(0, 1'b1, 2'd3, 32'h20, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, "st w3 0x20");
        access(0, 1'b0, 2'd2, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0, "ld_w 0x20");
        check("ld_w 0x20 rdata", rdata_v[0], 32'h11223344);

        // Address wrap modulo DEPTH*4
        access(0, 1'b1, 2'd2, 32'h1000, 32'h12345678, 1'b0, 1'b0, 1'b0, "st_w 0x1000");
        access(0, 1'b0, 2'd2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, "ld_w 0x0 wrap");
        check("ld_w 0x0 wrap rdata", rdata_v[0], 32'h12345678);

        // LATENCY=0: req held across three loads, ack every other cycle
        access(1, 1'b1, 2'd2, 32'h10, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, "l0 st_w 0x10");
        req_v[1]   = 1'b1;
        write_v[1] = 1'b0;
        width_v[1] = 2'd2;
        addr_v[1]  = 32'h10;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check($sformatf("l0 stream ack cycle T+%0d", i), 32'(ack_v[1]), (i % 2 == 1) ? 32'd1 : 32'd0);
            $display("[TB] u1 stream cycle T+%0d ack=%0b", i, ack_v[1]);
        end
        req_v[1] = 1'b0;
        check("l0 stream rdata", rdata_v[1], 32'hCAFEF00D);
        tick();

        // LATENCY=3: normal traffic, req dropped mid-wait
        access(2, 1'b1, 2'd2, 32'h40, 32'h55AA55AA, 1'b0, 1'b0, 1'b0, "l3 st_w 0x40");
        access(2, 1'b0, 2'd2, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, "l3 ld_w 0x40");
        check("l3 ld_w 0x40 rdata", rdata_v[2], 32'h55AA55AA);
        access(2, 1'b1, 2'd2, 32'h44, 32'h01020304, 1'b0, 1'b0, 1'b0, "l3 st_w 0x44");
        access(2, 1'b0, 2'd2, 32'h44, 32'h0, 1'b0, 1'b1, 1'b0, "l3 ld_w 0x44 req drop");
        check("l3 req drop rdata", rdata_v[2], 32'h01020304);

        // Reset in the second wait cycle aborts the store
        req_v[2]   = 1'b1;
        write_v[2] = 1'b1;
        width_v[2] = 2'd2;
        addr_v[2]  = 32'h40;
        wdata_v[2] = 32'h0BADF00D;
        tick();
        check("l3 abort wait1 ack", 32'(ack_v[2]), 32'd0);
        tick();
        check("l3 abort wait2 ack", 32'(ack_v[2]), 32'd0);
        reset_n_v[2] = 1'b0;
        req_v[2]     = 1'b0;
        tick();
        reset_n_v[2] = 1'b1;
        check("l3 post-reset ack", 32'(ack_v[2]), 32'd0);
        check("l3 post-reset rdata", rdata_v[2], 32'd0);
        $display("[TB] u2 reset applied in second wait cycle of store");
        access(2, 1'b0, 2'd2, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, "l3 ld_w 0x40 after reset");
        check("l3 word unchanged after abort", rdata_v[2], 32'h55AA55AA);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
